// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the byte-serial memory command protocol (issuer and responder).
package mem_cmd_pkg;

    localparam logic [7:0] CMD_READ  = 8'h30;
    localparam logic [7:0] CMD_WRITE = 8'h31;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_CMD    = 3'd1;
    localparam logic [2:0] ST_SEND_ADDR   = 3'd2;
    localparam logic [2:0] ST_SEND_DATA   = 3'd3;
    localparam logic [2:0] ST_WAIT_RSP    = 3'd4;
    localparam logic [2:0] ST_CAPTURE_RSP = 3'd5;

    typedef enum logic [2:0] {
        StIdle       = ST_IDLE,
        StSendCmd    = ST_SEND_CMD,
        StSendAddr   = ST_SEND_ADDR,
        StSendData   = ST_SEND_DATA,
        StWaitRsp    = ST_WAIT_RSP,
        StCaptureRsp = ST_CAPTURE_RSP
    } state_e;

endpackage

// File: rtl/mem_cmd_issuer_if.sv
// Request, TX/RX FIFO and response signals of the memory command issuer.
interface mem_cmd_issuer_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [FIFO_WIDTH-1:0] req_wdata;
    logic                  tx_fifo_full;
    logic                  tx_fifo_wr_en;
    logic [FIFO_WIDTH-1:0] tx_dout;
    logic                  rx_fifo_empty;
    logic                  rx_fifo_rd_en;
    logic [FIFO_WIDTH-1:0] rx_din;
    logic                  rsp_valid;
    logic [FIFO_WIDTH-1:0] rsp_data;
    logic                  rsp_timeout;
    logic                  cmd_done;
    logic [5:0]            state_leds;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, tx_fifo_full, rx_fifo_empty, rx_din,
        output req_ready, tx_fifo_wr_en, tx_dout, rx_fifo_rd_en, rsp_valid, rsp_data,
               rsp_timeout, cmd_done, state_leds
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, tx_fifo_full, rx_fifo_empty, rx_din,
        input  req_ready, tx_fifo_wr_en, tx_dout, rx_fifo_rd_en, rsp_valid, rsp_data,
               rsp_timeout, cmd_done, state_leds
    );
endinterface

// File: rtl/rsp_timer.sv
// Clear/enable/expire down-counter bounding how long a read waits for its reply byte.
module rsp_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= W'(CYCLES - 1);
        end else if (enable && count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    // Expiry marks the CYCLES-th enabled cycle since the last clear.
    assign expire = enable && (count_q == '0);
endmodule

// File: rtl/mem_cmd_issuer.sv
// Host-side initiator: serializes one read/write request into TX bytes and collects the read echo.
// Optional MEM_CMD_RSP_TIMEOUT_EN aborts a read after TIMEOUT_CYCLES cycles without a reply.
module mem_cmd_issuer
    import mem_cmd_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
`ifdef MEM_CMD_RSP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input logic             clk,
    input logic             rst,
    mem_cmd_issuer_if.master bus
);
    state_e                state_q, state_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [FIFO_WIDTH-1:0] wdata_q;
    logic [FIFO_WIDTH-1:0] rsp_data_q;
    logic                  rsp_valid_q;
    logic                  cmd_done_q;
    logic                  expired;

`ifdef MEM_CMD_RSP_TIMEOUT_EN
    logic rsp_timeout_q;

    rsp_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != StWaitRsp),
        .enable (state_q == StWaitRsp),
        .expire (expired)
    );

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign expired         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        bus.req_ready     = 1'b0;
        bus.tx_fifo_wr_en = 1'b0;
        bus.tx_dout       = '0;
        bus.rx_fifo_rd_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = StSendCmd;
            end
            StSendCmd: begin
                bus.tx_dout       = FIFO_WIDTH'(write_q ? CMD_WRITE : CMD_READ);
                bus.tx_fifo_wr_en = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full) state_d = StSendAddr;
            end
            StSendAddr: begin
                bus.tx_dout       = FIFO_WIDTH'(addr_q);
                bus.tx_fifo_wr_en = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full) state_d = write_q ? StSendData : StWaitRsp;
            end
            StSendData: begin
                bus.tx_dout       = wdata_q;
                bus.tx_fifo_wr_en = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full) state_d = StIdle;
            end
            StWaitRsp: begin
                // A byte present on the expiry cycle wins over the timeout.
                bus.rx_fifo_rd_en = !bus.rx_fifo_empty;
                if (!bus.rx_fifo_empty) state_d = StCaptureRsp;
                else if (expired)       state_d = StIdle;
            end
            StCaptureRsp: state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            cmd_done_q    <= 1'b0;
`ifdef MEM_CMD_RSP_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= 1'b0;
            cmd_done_q    <= 1'b0;
`ifdef MEM_CMD_RSP_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            if (state_q == StWaitRsp && bus.rx_fifo_empty && expired) begin
                rsp_data_q    <= '0;
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b1;
                cmd_done_q    <= 1'b1;
            end
`endif
            if (state_q == StIdle && bus.req_valid) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == StSendData && !bus.tx_fifo_full) cmd_done_q <= 1'b1;
            if (state_q == StCaptureRsp) begin
                rsp_data_q  <= bus.rx_din;
                rsp_valid_q <= 1'b1;
                cmd_done_q  <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.cmd_done   = cmd_done_q;
    assign bus.state_leds = {3'b000, state_q};
endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Scoreboard bench for mem_cmd_issuer; build with MEM_CMD_RSP_TIMEOUT_EN to cover the read timeout.
module tb_mem_cmd_issuer;
    localparam int FW = 8;
    localparam int AW = 8;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] data;
        logic       to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_cmd_issuer_if #(.FIFO_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

    mem_cmd_issuer #(
        .FIFO_WIDTH (FW),
        .ADDR_WIDTH (AW)
`ifdef MEM_CMD_RSP_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    bit         rand_bp = 0;
    logic [7:0] tx_exp[$];
    rsp_t       rsp_exp[$];
    logic [7:0] rx_q[$];
    int         done_pending = 0;
    int         last_accept_cyc = 0, last_rsp_cyc = 0, last_pop_cyc = 0, last_done_cyc = 0;
    int         pop_cnt = 0, rsp_cnt = 0, tx_cnt = 0, accept_cnt = 0;
    logic [7:0] last_rsp_val = 8'h00;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RX FIFO model: a pop presents the byte on rx_din the following cycle.
    always @(posedge clk) begin
        if (bus.rx_fifo_rd_en && rx_q.size() != 0) bus.rx_din <= rx_q.pop_front();
        bus.rx_fifo_empty <= (rx_q.size() == 0);
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.tx_fifo_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.req_valid && bus.req_ready) begin
                last_accept_cyc = cyc + 1;
                accept_cnt++;
            end
            if (bus.tx_fifo_wr_en) begin
                tx_cnt++;
                chk("tx_push_while_full", {31'd0, bus.tx_fifo_full}, 32'd0);
                if (tx_exp.size() == 0) chk("tx_unexpected", {24'd0, bus.tx_dout}, 32'hFFFF_FFFF);
                else chk("tx_byte", {24'd0, bus.tx_dout}, {24'd0, tx_exp.pop_front()});
            end
            if (bus.rx_fifo_rd_en) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                chk("rx_pop_state", {26'd0, bus.state_leds}, 32'd4);
                chk("rx_pop_while_empty", {31'd0, bus.rx_fifo_empty}, 32'd0);
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                if (rsp_exp.size() == 0) begin
                    chk("rsp_unexpected", {24'd0, bus.rsp_data}, 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = rsp_exp.pop_front();
                    chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
                    chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e.to});
                    chk("rsp_with_done", {31'd0, bus.cmd_done}, 32'd1);
                end
            end else if (bus.rsp_timeout) begin
                chk("timeout_without_valid", 32'd1, 32'd0);
            end
            if (bus.cmd_done) begin
                last_done_cyc = cyc;
                if (done_pending == 0) chk("done_unexpected", 32'd1, 32'd0);
                else done_pending--;
            end
        end
    end

    task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            tx_exp.push_back(w ? 8'h31 : 8'h30);
            tx_exp.push_back(a);
            if (w) tx_exp.push_back(d);
            done_pending++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rx_supply(input logic [7:0] b);
        rx_q.push_back(b);
        rsp_exp.push_back('{data: b, to: 1'b0});
        last_rsp_val = b;
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_exp.size() != 0 || rsp_exp.size() != 0 || done_pending != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int p0, t0, r0, a0;
        logic [7:0] b1, b2;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.tx_fifo_full = 1'b0;
        bus.rx_din       = '0;
        bus.rx_fifo_empty = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state_leds", {26'd0, bus.state_leds}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_tx_wr_en", {31'd0, bus.tx_fifo_wr_en}, 32'd0);
        chk("rst_rx_rd_en", {31'd0, bus.rx_fifo_rd_en}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        chk("rst_cmd_done", {31'd0, bus.cmd_done}, 32'd0);
        chk("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Plain write: three consecutive pushes, done three cycles after acceptance.
        p0 = pop_cnt;
        issue(1'b1, 8'h12, 8'hA5);
        bus.req_valid = 1'b0;
        drain();
        chk("wr_latency", last_done_cyc - last_accept_cyc, 32'd3);
        chk("wr_no_rx_pop", pop_cnt - p0, 32'd0);

        // Read with the reply byte supplied five cycles later.
        p0 = pop_cnt;
        issue(1'b0, 8'h40, 8'h00);
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_supply(8'h7E);
        drain();
        chk("rd_one_pop", pop_cnt - p0, 32'd1);
        chk("rd_rsp_latency", last_rsp_cyc - last_pop_cyc, 32'd2);

        // TX full for four cycles while the address byte is pending.
        issue(1'b1, 8'h5C, 8'h3D);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.tx_fifo_full = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.tx_fifo_full = 1'b0;
        drain();
        chk("bp_latency", last_done_cyc - last_accept_cyc, 32'd7);

        // Two reads with req_valid held: the second is taken the cycle after the first reply.
        a0 = accept_cnt;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        issue(1'b0, 8'hA1, 8'h00);
        rx_supply(b1);
        issue(1'b0, 8'hA2, 8'h00);
        chk("b2b_accept_after_rsp", last_accept_cyc, last_rsp_cyc + 1);
        rx_supply(b2);
        bus.req_valid = 1'b0;
        drain();
        chk("b2b_accept_cnt", accept_cnt - a0, 32'd2);

        // Reset while holding in SEND_ADDR abandons the packet.
        issue(1'b1, 8'hC3, 8'h99);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.tx_fifo_full = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_exp.delete();
        done_pending = 0;
        bus.tx_fifo_full = 1'b0;
        t0 = tx_cnt;
        @(negedge clk);
        chk("midrst_state_leds", {26'd0, bus.state_leds}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_push", tx_cnt - t0, 32'd0);
        @(posedge clk);
        #1;

        // Read that never gets a reply.
        r0 = rsp_cnt;
        issue(1'b0, 8'h66, 8'h00);
        bus.req_valid = 1'b0;
`ifdef MEM_CMD_RSP_TIMEOUT_EN
        rsp_exp.push_back('{data: 8'h00, to: 1'b1});
        last_rsp_val = 8'h00;
        drain();
        chk("timeout_latency", last_rsp_cyc - last_accept_cyc, TO + 2);
        chk("timeout_one_rsp", rsp_cnt - r0, 32'd1);
`else
        repeat (40) @(negedge clk);
        chk("wait_forever_state", {26'd0, bus.state_leds}, 32'd4);
        chk("wait_forever_no_rsp", rsp_cnt - r0, 32'd0);
        @(posedge clk);
        #1;
        rx_supply(8'h99);
        drain();
`endif

        // Random mix with random TX backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bit w;
            w = $urandom_range(0, 1) == 1;
            issue(w, 8'($urandom), 8'($urandom));
            if (!w) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                rx_supply(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        bus.tx_fifo_full = 1'b0;
        drain();

        chk("rsp_data_hold", {24'd0, bus.rsp_data}, {24'd0, last_rsp_val});
        chk("end_tx_exp_empty", tx_exp.size(), 32'd0);
        chk("end_rsp_exp_empty", rsp_exp.size(), 32'd0);
        chk("end_rx_fifo_empty", rx_q.size(), 32'd0);
        chk("end_done_pending", done_pending, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
